// File: rtl/sram_arbiter_pkg.sv
// Shared types and widths for the two-port SRAM request arbiter.
package sram_arb_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_WAIT_WR = 3'd3,
        ST_DONE    = 3'd4
    } arb_state_e;

    // One latched transaction as presented to the SRAM controller.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rh_wl;
        logic [DATA_W-1:0] wdata;
    } sram_txn_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side and controller-side bundles for the SRAM arbiter.
interface sram_arb_req_if;
    import sram_arb_pkg::*;

    logic              req;
    logic              rh_wl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, rh_wl, addr, wdata, input ack, rdata, err);
    modport slave  (input req, rh_wl, addr, wdata, output ack, rdata, err);
endinterface

interface sram_arb_mem_if;
    import sram_arb_pkg::*;

    logic              sram_req;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_rh_wl;
    logic [DATA_W-1:0] sram_data_w;
    logic [DATA_W-1:0] sram_data_r;
    logic              sram_data_r_en;

    modport master (output sram_req, sram_addr, sram_rh_wl, sram_data_w,
                    input  sram_data_r, sram_data_r_en);
    modport slave  (input  sram_req, sram_addr, sram_rh_wl, sram_data_w,
                    output sram_data_r, sram_data_r_en);
endinterface

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// port that was not served last.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    // One-hot winner selection from the request vector and last owner.
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller request port between
// two requesters. One transaction in flight; every output is registered.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no transaction; pick a winner when any port requests
// ST_ISSUE   | single-cycle sram_req pulse, counter cleared
// ST_WAIT_RD | waiting for sram_data_r_en, bounded by RD_TIMEOUT
// ST_WAIT_WR | controller occupancy count of WR_CYCLES after a write
// ST_DONE    | one-cycle ack to the granted port, update round-robin owner
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WR_CYCLES  = 3,
    parameter int RD_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset,
    sram_arb_req_if.slave  p0,
    sram_arb_req_if.slave  p1,
    sram_arb_mem_if.master mem,
    output logic           busy,
    output logic [1:0]     grant
);

    localparam int CNT_MAX = max2(WR_CYCLES, RD_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_e state_q, state_d;

    sram_txn_t                txn_q, txn_d;
    logic [1:0]               grant_q, grant_d;
    logic                     last_q, last_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]               err_q, err_d;
    logic [1:0]               ack_q, ack_d;
    logic                     sram_req_q, sram_req_d;
    logic                     busy_q, busy_d;

    logic [1:0] req_vec;
    logic [1:0] pick_gnt;
    logic       gidx;
    logic       rd_to;
    logic       wr_end;

    assign req_vec = {p1.req, p0.req};
    assign gidx    = grant_q[1];
    assign cnt_inc = cnt_q + 1'b1;
    assign rd_to   = (cnt_inc == CNT_W'(RD_TIMEOUT));
    assign wr_end  = (cnt_inc == CNT_W'(WR_CYCLES));

    rr_pick2 u_pick (
        .req_i   (req_vec),
        .last_i  (last_q),
        .grant_o (pick_gnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (|req_vec) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = txn_q.rh_wl ? ST_WAIT_RD : ST_WAIT_WR;
            ST_WAIT_RD: if (mem.sram_data_r_en || rd_to) state_d = ST_DONE;
            ST_WAIT_WR: if (wr_end) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; outputs are decoded from state_d so
    // they can be registered and still line up with the state they belong to.
    always_comb begin
        txn_d      = txn_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ack_d      = 2'b00;
        sram_req_d = (state_d == ST_ISSUE);
        busy_d     = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    grant_d = pick_gnt;
                    if (pick_gnt[1]) begin
                        txn_d = '{addr: p1.addr, rh_wl: p1.rh_wl, wdata: p1.wdata};
                    end else begin
                        txn_d = '{addr: p0.addr, rh_wl: p0.rh_wl, wdata: p0.wdata};
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
            end
            ST_WAIT_RD: begin
                // A strobe in the last waiting cycle still wins over timeout.
                if (mem.sram_data_r_en) begin
                    rdata_d[gidx] = mem.sram_data_r;
                    err_d[gidx]   = 1'b0;
                    ack_d[gidx]   = 1'b1;
                end else if (rd_to) begin
                    rdata_d[gidx] = '0;
                    err_d[gidx]   = 1'b1;
                    ack_d[gidx]   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_WR: begin
                if (wr_end) begin
                    err_d[gidx] = 1'b0;
                    ack_d[gidx] = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                last_d  = gidx;
                grant_d = 2'b00;
            end
            default: begin
                grant_d = 2'b00;
            end
        endcase
    end

    // Registered outputs and datapath; last owner resets to port 1 so
    // port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            txn_q      <= '0;
            grant_q    <= 2'b00;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 2'b00;
            ack_q      <= 2'b00;
            sram_req_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            txn_q      <= txn_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            sram_req_q <= sram_req_d;
            busy_q     <= busy_d;
        end
    end

    assign p0.ack   = ack_q[0];
    assign p0.rdata = rdata_q[0];
    assign p0.err   = err_q[0];
    assign p1.ack   = ack_q[1];
    assign p1.rdata = rdata_q[1];
    assign p1.err   = err_q[1];

    assign mem.sram_req    = sram_req_q;
    assign mem.sram_addr   = txn_q.addr;
    assign mem.sram_rh_wl  = txn_q.rh_wl;
    assign mem.sram_data_w = txn_q.wdata;

    assign busy  = busy_q;
    assign grant = grant_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: writes, reads, timeout, round-robin,
// mid-transaction reset and stray read strobes.
module tb_sram_arbiter;

    logic       clk;
    logic       reset;
    logic       busy;
    logic [1:0] grant;

    int n_checks = 0;
    int n_fail   = 0;

    sram_arb_req_if p0_if ();
    sram_arb_req_if p1_if ();
    sram_arb_mem_if mem_if ();

    sram_arbiter #(
        .WR_CYCLES  (3),
        .RD_TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .p0    (p0_if),
        .p1    (p1_if),
        .mem   (mem_if),
        .busy  (busy),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"},   32'(busy), 32'h0);
        check_eq({tag, "_grant"},  32'(grant), 32'h0);
        check_eq({tag, "_sreq"},   32'(mem_if.sram_req), 32'h0);
        check_eq({tag, "_saddr"},  32'(mem_if.sram_addr), 32'h0);
        check_eq({tag, "_sdir"},   32'(mem_if.sram_rh_wl), 32'h0);
        check_eq({tag, "_sdw"},    32'(mem_if.sram_data_w), 32'h0);
        check_eq({tag, "_acks"},   32'({p1_if.ack, p0_if.ack}), 32'h0);
        check_eq({tag, "_errs"},   32'({p1_if.err, p0_if.err}), 32'h0);
        check_eq({tag, "_rdata0"}, 32'(p0_if.rdata), 32'h0);
        check_eq({tag, "_rdata1"}, 32'(p1_if.rdata), 32'h0);
    endtask

    task automatic drive_req(input int port, input logic req, input logic rh_wl,
                             input logic [18:0] addr, input logic [7:0] wdata);
        if (port == 0) begin
            p0_if.req = req; p0_if.rh_wl = rh_wl; p0_if.addr = addr; p0_if.wdata = wdata;
        end else begin
            p1_if.req = req; p1_if.rh_wl = rh_wl; p1_if.addr = addr; p1_if.wdata = wdata;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge with the DUT idle. Cycle n is the negedge after
    // edge n-1, counting edge 0 as the one that samples the request.
    // strobe_n = 0 means the controller never answers.
    task automatic do_txn(input string tag, input int port, input logic rh_wl,
                          input logic [18:0] addr, input logic [7:0] wdata,
                          input int strobe_n, input logic [7:0] sdata, input int exp_ack);
        int          ack_n = -1;
        int          nreq = 0;
        int          other_acks = 0;
        logic [18:0] s_addr = '0;
        logic        s_dir = 1'b0;
        logic [7:0]  s_dw = '0;
        logic [1:0]  s_gnt = '0;
        logic        own_ack, oth_ack;
        drive_req(port, 1'b1, rh_wl, addr, wdata);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            mem_if.sram_data_r_en = 1'b0;
            own_ack = (port == 0) ? p0_if.ack : p1_if.ack;
            oth_ack = (port == 0) ? p1_if.ack : p0_if.ack;
            if (oth_ack) other_acks++;
            if (mem_if.sram_req) begin
                nreq++;
                s_addr = mem_if.sram_addr;
                s_dir  = mem_if.sram_rh_wl;
                s_dw   = mem_if.sram_data_w;
                s_gnt  = grant;
            end
            if (own_ack) begin
                ack_n = n;
                drive_req(port, 1'b0, rh_wl, addr, wdata);
                break;
            end
            if (n == strobe_n) begin
                mem_if.sram_data_r    = sdata;
                mem_if.sram_data_r_en = 1'b1;
            end
        end
        mem_if.sram_data_r_en = 1'b0;
        drive_req(port, 1'b0, rh_wl, addr, wdata);
        check_eq({tag, "_ack_cycle"}, 32'(ack_n), 32'(exp_ack));
        check_eq({tag, "_nreq"}, 32'(nreq), 32'd1);
        check_eq({tag, "_saddr"}, 32'(s_addr), 32'(addr));
        check_eq({tag, "_sdir"}, 32'(s_dir), 32'(rh_wl));
        if (!rh_wl) check_eq({tag, "_sdw"}, 32'(s_dw), 32'(wdata));
        check_eq({tag, "_grant"}, 32'(s_gnt), (port == 0) ? 32'h1 : 32'h2);
        check_eq({tag, "_other_ack"}, 32'(other_acks), 32'd0);
        @(negedge clk);
    endtask

    logic [1:0] rr_exp [4];

    initial begin
        int n_sreq;
        int n_ack;
        int last_ack_n;
        int stray_acks;
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        reset = 1'b1;
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        mem_if.sram_data_r    = '0;
        mem_if.sram_data_r_en = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Port 0 write, then port 1 read with strobe two cycles after ISSUE.
        do_txn("p0_wr", 0, 1'b0, 19'h00123, 8'hA5, 0, 8'h00, 5);
        check_eq("p0_wr_err", 32'(p0_if.err), 32'h0);
        do_txn("p1_rd", 1, 1'b1, 19'h7FFFF, 8'h00, 3, 8'h3C, 4);
        check_eq("p1_rd_rdata", 32'(p1_if.rdata), 32'h3C);
        check_eq("p1_rd_err", 32'(p1_if.err), 32'h0);

        // Stray strobe while idle must not disturb anything.
        mem_if.sram_data_r    = 8'hFF;
        mem_if.sram_data_r_en = 1'b1;
        @(negedge clk);
        mem_if.sram_data_r_en = 1'b0;
        stray_acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (p0_if.ack || p1_if.ack) stray_acks++;
        end
        check_eq("stray_acks", 32'(stray_acks), 32'd0);
        check_eq("stray_rdata1", 32'(p1_if.rdata), 32'h3C);
        check_eq("stray_busy", 32'(busy), 32'h0);

        // Both ports requesting continuously from reset: strict alternation.
        apply_reset();
        drive_req(0, 1'b1, 1'b0, 19'h00010, 8'h11);
        drive_req(1, 1'b1, 1'b0, 19'h00020, 8'h22);
        n_sreq = 0;
        n_ack = 0;
        last_ack_n = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (mem_if.sram_req) begin
                check_eq("rr_grant", 32'(grant), (n_sreq < 4) ? 32'(rr_exp[n_sreq]) : 32'h0);
                if (last_ack_n >= 0) check_eq("rr_gap", 32'(n - last_ack_n), 32'd2);
                n_sreq++;
            end
            if (p0_if.ack || p1_if.ack) begin
                check_eq("rr_ack_port", 32'({p1_if.ack, p0_if.ack}),
                         (n_ack < 4) ? 32'(rr_exp[n_ack]) : 32'h0);
                n_ack++;
                last_ack_n = n;
                if (n_ack == 4) begin
                    p0_if.req = 1'b0;
                    p1_if.req = 1'b0;
                    break;
                end
            end
        end
        p0_if.req = 1'b0;
        p1_if.req = 1'b0;
        check_eq("rr_sreq_count", 32'(n_sreq), 32'd4);
        check_eq("rr_ack_count", 32'(n_ack), 32'd4);
        repeat (2) @(negedge clk);
        check_eq("rr_idle_busy", 32'(busy), 32'h0);

        // Good read, then timeout clears rdata and flags err, then a write.
        do_txn("p0_rd", 0, 1'b1, 19'h00456, 8'h00, 2, 8'h5A, 3);
        check_eq("p0_rd_rdata", 32'(p0_if.rdata), 32'h5A);
        do_txn("p0_to", 0, 1'b1, 19'h00789, 8'h00, 0, 8'h00, 17);
        check_eq("p0_to_err", 32'(p0_if.err), 32'h1);
        check_eq("p0_to_rdata", 32'(p0_if.rdata), 32'h00);
        do_txn("p0_wr2", 0, 1'b0, 19'h00ABC, 8'hC3, 0, 8'h00, 5);
        check_eq("p0_wr2_err", 32'(p0_if.err), 32'h0);

        // Reset in the middle of a write.
        drive_req(1, 1'b1, 1'b0, 19'h01234, 8'h77);
        repeat (3) @(negedge clk);
        check_eq("mid_state_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        drive_req(1, 1'b0, 1'b0, 19'h01234, 8'h77);
        @(negedge clk);
        check_outputs_zero("mid_reset");
        reset = 1'b0;
        stray_acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (p0_if.ack || p1_if.ack) stray_acks++;
        end
        check_eq("mid_reset_no_ack", 32'(stray_acks), 32'd0);
        do_txn("post_rst_wr", 0, 1'b0, 19'h00042, 8'h3E, 0, 8'h00, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter that shares the single SRAM controller request interface (request pulse, 19-bit address, read-high/write-low, 8-bit write data, read data plus read-data-enable) between two requesters, e.g. the SPI debug port and an on-chip pattern tester. It latches one transaction at a time, issues a single-cycle `sram_req` to the SRAM controller, and tracks completion. Reads complete on `sram_data_r_en`; writes complete after a fixed occupancy count. It returns a per-port acknowledge with read data, or an error on read timeout.

## Interface
- `WR_CYCLES`, default 3: cycles the controller is held busy after a write request.
- `RD_TIMEOUT`, default 15: maximum cycles to wait for `sram_data_r_en` before aborting the read.
- `clk`  in  1  single system clock (PLL output).
- `reset`  in  1  synchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  level request; held with stable fields until ack.
- `p0_rh_wl`, `p1_rh_wl`  in  1  1 = read, 0 = write.
- `p0_addr`, `p1_addr`  in  19  byte address.
- `p0_wdata`, `p1_wdata`  in  8  write data.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_rdata`, `p1_rdata`  out  8  read data; valid with ack; held until that port's next ack.
- `p0_err`, `p1_err`  out  1  valid with ack; 1 = read timed out.
- `sram_req`  out  1  one-cycle request pulse to the SRAM controller.
- `sram_addr`  out  19  latched address.
- `sram_rh_wl`  out  1  latched direction.
- `sram_data_w`  out  8  latched write data.
- `sram_data_r`  in  8  read data from the controller.
- `sram_data_r_en`  in  1  read-data-valid strobe from the controller.
- `busy`  out  1  high in any state other than IDLE.
- `grant`  out  2  one-hot owner of the current transaction; 0 when idle.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR, DONE.
- **IDLE**
  - If any request is high, select a winner, latch its addr/rh_wl/wdata into the `sram_*` registers, set `grant`, and go to ISSUE.
  - Round-robin: when both ports request, grant the port not served last. `last` resets to port 1, so port 0 wins the first tie.
  - A lone requester always wins.
- **ISSUE**
  - `sram_req` = 1 for exactly this cycle.
  - Next state is WAIT_RD when `sram_rh_wl`=1, otherwise WAIT_WR.
  - Clear the counter.
- **WAIT_RD**
  - On `sram_data_r_en`=1, capture `sram_data_r` into the granted port's rdata, set err=0, and go to DONE.
  - Otherwise increment the counter. When the counter reaches `RD_TIMEOUT`, set rdata=0x00, err=1, and go to DONE.
- **WAIT_WR**
  - Increment the counter. When it reaches `WR_CYCLES`, set err=0 and go to DONE.
- **DONE**
  - The granted port's ack = 1 for this cycle only. Update `last`, then go to IDLE.
  - The requester must drop req by the following edge. A req still high in IDLE is treated as a new transaction.
- **Ignored strobes:** `sram_data_r_en` outside WAIT_RD is ignored, as is the non-granted port's request while busy.
- **Counter:** width is `$clog2(max(WR_CYCLES,RD_TIMEOUT)+1)` and it never wraps.
- **Reset values:** all outputs are 0 (`sram_addr`, `sram_data_w`, rdata, err, ack, `sram_req`, `busy`, `grant`). Reset mid-transaction returns to IDLE with no ack. The SRAM controller shares the same reset, so it also drops the transaction.

## Timing
- Cycle 0 is the IDLE edge that samples req.
- Write latency: ISSUE at cycle 1, WAIT_WR for `WR_CYCLES` cycles, ack at cycle `WR_CYCLES`+2 (5 by default).
- Read latency: strobe arriving k cycles after ISSUE (k ≥ 1) gives ack at cycle k+2.
- Read timeout: ack with err at cycle `RD_TIMEOUT`+2.
- Throughput: minimum gap from one ack to the next `sram_req` is 2 cycles (IDLE, ISSUE).
- All outputs are registered. There is no combinational path from requester inputs to `sram_*`.

## Structure
- Package `sram_arb_pkg` holds:
  - the state enum,
  - `ADDR_W`=19 and `DATA_W`=8,
  - the transaction record (addr, rh_wl, wdata).
- Sub-module `rr_pick2`: combinational two-way round-robin picker. Inputs: req[1:0], last. Output: one-hot grant.
- Counter and data capture stay in `sram_arbiter`.

## Test plan
- Port 0 write addr 0x00123, data 0xA5 → one `sram_req` with `sram_rh_wl`=0, `sram_addr`=0x00123, `sram_data_w`=0xA5; `p0_ack` 5 cycles after req is sampled; `p1_ack` never fires.
- Port 1 read addr 0x7FFFF, controller strobes 0x3C two cycles after `sram_req` → `p1_rdata`=0x3C, `p1_err`=0, `p1_ack` at cycle 4.
- Both ports request from reset, and both re-raise immediately after each ack → grant order 0, 1, 0, 1; exactly one `sram_req` per transaction.
- Read with no strobe → `p0_ack` with `p0_err`=1 and `p0_rdata`=0x00 at cycle 17; a following write on port 0 completes normally.
- Reset asserted during WAIT_WR → next cycle all outputs are 0, no ack fires; a new request after reset issues normally.
- Stray `sram_data_r_en` with 0xFF while idle → no ack, and previously captured rdata is unchanged.
